uart_tx_arbiter: RTL

Shares the single SoC UART transmitter between N byte-stream requesters, e.g. the LM32 UART peripheral path and the GPIO pulse-capture/sensor reporting engine. It arbitrates round-robin at packet granularity and keeps the grant locked until the requester's last byte. It paces writes against the UART core's tx_busy. A timeout releases a stalled owner so a hung source cannot block the link.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter sharing one UART transmitter
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req[N]              per-requester byte valid, held with data/last until ack
//   data[8*N]           requester i byte on bits [8i+7:8i]
//   last[N]             byte closes the requester's packet
//   ack[N]              one-cycle pulse, byte of requester i taken
//   grant[N]            one-hot current owner, 0 when unlocked
//   locked              packet in progress
//   tx_wr, tx_data      one-cycle write strobe and byte toward the UART core
//   tx_busy             UART core busy (rises at most one cycle after tx_wr)
//   timeout_err         one-cycle pulse when a stalled owner is released

module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1000,
    parameter int TO_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] data,
    input  logic [N-1:0]   last,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   grant,
    output logic           locked,
    output logic           tx_wr,
    output logic [7:0]     tx_data,
    input  logic           tx_busy,
    output logic           timeout_err
);
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SEND, HOLD, DRAIN} state_t;

    state_t          state, state_n;
    logic            guard_q, guard_n;
    logic [PW-1:0]   owner, owner_n;
    logic [PW-1:0]   rr_ptr, rr_n;
    logic            last_q, last_n;
    logic [TO_W-1:0] to_cnt, cnt_n;
    logic [N-1:0]    ack_n, grant_n;
    logic            locked_n, tx_wr_n, timeout_n;
    logic [7:0]      tx_data_n;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW-1:0]   owner_next;

    // Round-robin search starting at rr_ptr; first set request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign owner_next = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);

    always_comb begin
        state_n   = state;
        guard_n   = guard_q;
        owner_n   = owner;
        rr_n      = rr_ptr;
        last_n    = last_q;
        cnt_n     = '0;
        ack_n     = '0;
        grant_n   = grant;
        locked_n  = locked;
        tx_wr_n   = 1'b0;
        tx_data_n = tx_data;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_n  = win;
                    grant_n  = N'(1) << win;
                    locked_n = 1'b1;
                    state_n  = SEND;
                end
            end
            SEND: begin
                // The timeout check wins over a late request so a counter that
                // has reached its limit always produces exactly one release.
                if (TIMEOUT != 0 && to_cnt == TO_W'(TIMEOUT)) begin
                    grant_n   = '0;
                    locked_n  = 1'b0;
                    rr_n      = owner_next;
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else if (req[owner] && !tx_busy) begin
                    tx_wr_n   = 1'b1;
                    ack_n     = N'(1) << owner;
                    tx_data_n = data[owner*8 +: 8];
                    last_n    = last[owner];
                    guard_n   = 1'b0;
                    state_n   = HOLD;
                end else if (!req[owner] && TIMEOUT != 0) begin
                    cnt_n = to_cnt + TO_W'(1);
                end
            end
            HOLD: begin
                // HOLD spans the strobe cycle plus one guard cycle in which
                // tx_busy may not have risen yet and is therefore ignored.
                if (!guard_q) begin
                    guard_n = 1'b1;
                end else begin
                    guard_n = 1'b0;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_n  = '0;
                        locked_n = 1'b0;
                        rr_n     = owner_next;
                        state_n  = IDLE;
                    end else begin
                        state_n = SEND;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            guard_q     <= 1'b0;
            owner       <= '0;
            rr_ptr      <= '0;
            last_q      <= 1'b0;
            to_cnt      <= '0;
            ack         <= '0;
            grant       <= '0;
            locked      <= 1'b0;
            tx_wr       <= 1'b0;
            tx_data     <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            guard_q     <= guard_n;
            owner       <= owner_n;
            rr_ptr      <= rr_n;
            last_q      <= last_n;
            to_cnt      <= cnt_n;
            ack         <= ack_n;
            grant       <= grant_n;
            locked      <= locked_n;
            tx_wr       <= tx_wr_n;
            tx_data     <= tx_data_n;
            timeout_err <= timeout_n;
        end
    end
endmodule
